calib_delay_sequencer: RTL
==========================

Name: calib_delay_sequencer

Overview:
- Controller that sequences the LACCP calibration-delay offset calculation datapath.
- Captures calibration-delay words received from the link partner and holds each one stable as the datapath's rx operand.
- Waits the datapath pipeline latency, then samples the fine-offset result, accumulates a power-of-two number of samples, checks their spread and publishes one averaged fine offset.
- Sits between the LACCP rx decoder and the fine-offset consumer (local clock alignment logic).

Parameters:
- kCalibDelayWidth, 12, width of signed calibration-delay words.
- kWidthLaccpFineOffset, 16, width of signed fine-offset result and output.
- kCalcLatency, 2, cycles from a stable operand to a valid datapath result.
- kNumAvgLog2, 2, log2 of samples per measurement (4 samples).
- kMaxSpread, 8, maximum allowed (max − min) over samples, in fine-offset LSBs.
- kTimeoutWidth, 16, width of the rx-wait timeout counter; timeout fires at all-ones.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begin a measurement
- link_up  in  1  LACCP link established
- rx_calib_valid  in  1  single-cycle strobe, new partner calib delay
- rx_calib_delay  in  kCalibDelayWidth  partner calib delay (signed)
- calc_calibdelay_rx  out  kCalibDelayWidth  held operand to the calculation datapath
- calc_result  in  kWidthLaccpFineOffset  datapath result (signed)
- fine_offset  out  kWidthLaccpFineOffset  averaged offset (signed), held until next publish
- fine_offset_valid  out  1  single-cycle pulse when fine_offset updates
- busy  out  1  high outside IDLE
- error  out  1  single-cycle pulse on abort
- err_code  out  2  00 none, 01 timeout, 10 spread, 11 link drop; held until next start

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, min/max, sample count and timer cleared.
- FSM states: IDLE, WAIT_RX, SETTLE, SAMPLE, CHECK, DONE, ERR.
- IDLE: start && link_up -> WAIT_RX. Clear the accumulator, count, timer and err_code. Set min to the most positive value and max to the most negative value. start while link_up=0 is ignored. start while busy is ignored.
- WAIT_RX: on rx_calib_valid, register rx_calib_delay into calc_calibdelay_rx, clear timer, -> SETTLE. Otherwise increment timer; at all-ones -> ERR with code 01.
- SETTLE: count kCalcLatency+1 cycles (one cycle for the operand register plus the datapath latency), then -> SAMPLE. rx_calib_valid during SETTLE is dropped and the operand is not changed.
- SAMPLE (1 cycle):
  - acc += sign-extended calc_result; acc width = kWidthLaccpFineOffset+kNumAvgLog2, so it cannot overflow.
  - Update min and max.
  - count++. If count reaches 2^kNumAvgLog2 -> CHECK, else -> WAIT_RX.
- CHECK (1 cycle): compute max−min at kWidthLaccpFineOffset+1 bits.
  - If result > kMaxSpread -> ERR code 10.
  - Else fine_offset <= acc >>> kNumAvgLog2 (arithmetic shift, rounds toward −inf), -> DONE.
- DONE: fine_offset_valid=1 for one cycle, -> IDLE.
- ERR: error=1 for one cycle, -> IDLE. fine_offset keeps its previous value.
- link_up low in any state other than IDLE/DONE/ERR -> ERR code 11 on the next cycle. This takes priority over timeout and spread in the same cycle.
- calc_calibdelay_rx keeps its last value in IDLE.
- Reset asserted mid-measurement returns to the full reset state immediately, with no valid or error pulse.
- Latency: from the last accepted rx_calib_valid, fine_offset_valid follows kCalcLatency+4 cycles later.

Decomposition:
- Shared package laccp_calib_pkg holds:
  - FSM state encoding.
  - err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_SPREAD, ERR_LINK).
  - Default widths kCalibDelayWidth and kWidthLaccpFineOffset.
- One natural sub-module, calib_sample_stats: accumulator plus min/max tracking, with clear, sample-enable, sum, min and max outputs.
- The FSM, timer and settle counter stay in the top.

Test Plan:
The bench instantiates the calculation datapath with CalibDelay=100, both sides 7-series, and result wired to calc_result.
- Nominal: start, then 4 rx words of 40 -> one fine_offset_valid pulse, fine_offset=60, err_code=00, busy drops the cycle after the pulse.
- Averaging and rounding: rx 40, 41, 42, 43 (diffs 60, 59, 58, 57, sum 234) -> fine_offset=58.
- Negative rounding: rx 110, 110, 111, 111 (diffs −10, −10, −11, −11, sum −42) -> fine_offset=−11, because −42>>>2 rounds toward −inf.
- Spread: rx 40, 40, 40, 60 (diffs 60, 60, 60, 40, spread 20 > 8) -> error pulse, err_code=10, fine_offset unchanged.
- Timeout with kTimeoutWidth=4: start, no rx -> error 16 cycles after entering WAIT_RX, err_code=01. A valid arriving in the same cycle as ERR is ignored.
- Link drop: deassert link_up during SETTLE of sample 2 -> error next cycle, err_code=11. A new start with link_up high completes normally. A reset pulse mid-SETTLE -> all outputs 0, no pulses.

Source files
------------

// File: rtl/laccp_calib_pkg.sv
// Shared definitions for the LACCP calibration-delay sequencer.
package laccp_calib_pkg;

  // Default operand / result widths of the offset calculation datapath
  localparam int kCalibDelayWidth      = 12;
  localparam int kWidthLaccpFineOffset = 16;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_RX = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  // Abort reasons reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_SPREAD  = 2'b10;
  localparam logic [1:0] ERR_LINK    = 2'b11;

endpackage

// File: rtl/calib_delay_sequencer_stats.sv
// Sample statistics: signed running sum plus min/max of the accepted samples.
module calib_sample_stats #(
  parameter int kDataWidth = 16,
  parameter int kAccWidth  = 18
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         i_clear,
  input  logic                         i_en,
  input  logic signed [kDataWidth-1:0] i_data,
  output logic signed [kAccWidth-1:0]  o_sum,
  output logic signed [kDataWidth-1:0] o_min,
  output logic signed [kDataWidth-1:0] o_max
);
  import laccp_calib_pkg::*;

  // Clear seeds min/max at the opposite extremes so the first sample wins both
  localparam logic signed [kDataWidth-1:0] LP_POS_MAX = {1'b0, {(kDataWidth-1){1'b1}}};
  localparam logic signed [kDataWidth-1:0] LP_NEG_MAX = {1'b1, {(kDataWidth-1){1'b0}}};

  logic signed [kAccWidth-1:0]  r_sum;
  logic signed [kDataWidth-1:0] r_min;
  logic signed [kDataWidth-1:0] r_max;
  logic signed [kAccWidth-1:0]  w_data_ext;

  assign w_data_ext = {{(kAccWidth-kDataWidth){i_data[kDataWidth-1]}}, i_data};

  // Accumulate and track extremes; clear wins over a same-cycle sample
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sum <= '0;
      r_min <= '0;
      r_max <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
      r_min <= LP_POS_MAX;
      r_max <= LP_NEG_MAX;
    end else if (i_en) begin
      r_sum <= r_sum + w_data_ext;
      if (i_data < r_min) r_min <= i_data;
      if (i_data > r_max) r_max <= i_data;
    end
  end

  assign o_sum = r_sum;
  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/calib_delay_sequencer.sv
// Sequences the LACCP calibration-delay offset datapath: captures partner
// calib words, waits the datapath latency, averages 2^kNumAvgLog2 results,
// checks their spread and publishes one fine offset.
module calib_delay_sequencer #(
  parameter int kCalibDelayWidth      = laccp_calib_pkg::kCalibDelayWidth,
  parameter int kWidthLaccpFineOffset = laccp_calib_pkg::kWidthLaccpFineOffset,
  parameter int kCalcLatency          = 2,
  parameter int kNumAvgLog2           = 2,
  parameter int kMaxSpread            = 8,
  parameter int kTimeoutWidth         = 16
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic                                start,
  input  logic                                link_up,
  input  logic                                rx_calib_valid,
  input  logic signed [kCalibDelayWidth-1:0]  rx_calib_delay,
  output logic signed [kCalibDelayWidth-1:0]  calc_calibdelay_rx,
  input  logic signed [kWidthLaccpFineOffset-1:0] calc_result,
  output logic signed [kWidthLaccpFineOffset-1:0] fine_offset,
  output logic                                fine_offset_valid,
  output logic                                busy,
  output logic                                error,
  output logic [1:0]                          err_code
);
  import laccp_calib_pkg::*;

  localparam int FW  = kWidthLaccpFineOffset;
  localparam int CW  = kCalibDelayWidth;
  localparam int AW  = FW + kNumAvgLog2;
  localparam int NCW = kNumAvgLog2 + 1;
  localparam int SW  = $clog2(kCalcLatency + 1) + 1;
  localparam int TW  = kTimeoutWidth;

  localparam logic [NCW-1:0]   LP_LAST_SAMPLE = NCW'((1 << kNumAvgLog2) - 1);
  localparam logic [SW-1:0]    LP_SETTLE_LAST = SW'(kCalcLatency);
  localparam logic signed [FW:0] LP_MAX_SPREAD = (FW+1)'(kMaxSpread);

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic [SW-1:0]         r_settle;
  logic [NCW-1:0]        r_count;
  logic signed [CW-1:0]  r_operand;
  logic signed [FW-1:0]  r_fine;
  logic                  r_fine_vld;
  logic                  r_busy;
  logic                  r_error;
  logic [1:0]            r_err_code;

  logic                  w_clear;
  logic                  w_sample_en;
  logic                  w_link_abort;
  logic signed [AW-1:0]  w_sum;
  logic signed [FW-1:0]  w_min;
  logic signed [FW-1:0]  w_max;
  logic signed [FW:0]    w_spread;
  logic                  w_unused_sum_lsb;

  // Stats are cleared on an accepted start and fed once per SAMPLE cycle
  assign w_clear     = (r_state == ST_IDLE) && start && link_up;
  assign w_sample_en = (r_state == ST_SAMPLE) && link_up;

  // Link loss aborts any in-flight measurement phase
  assign w_link_abort = !link_up &&
                        ((r_state == ST_WAIT_RX) || (r_state == ST_SETTLE) ||
                         (r_state == ST_SAMPLE)  || (r_state == ST_CHECK));

  // One extra bit so max-min of two FW-bit signed values cannot wrap
  assign w_spread = {w_max[FW-1], w_max} - {w_min[FW-1], w_min};

  // Average drops the low bits (floor division by 2^kNumAvgLog2)
  assign w_unused_sum_lsb = ^w_sum[kNumAvgLog2-1:0];

  calib_sample_stats #(
    .kDataWidth (FW),
    .kAccWidth  (AW)
  ) u_stats (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_clear (w_clear),
    .i_en    (w_sample_en),
    .i_data  (calc_result),
    .o_sum   (w_sum),
    .o_min   (w_min),
    .o_max   (w_max)
  );

  // Measurement FSM with registered outputs, timer and settle counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_settle   <= '0;
      r_count    <= '0;
      r_operand  <= '0;
      r_fine     <= '0;
      r_fine_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_fine_vld <= 1'b0;
      r_error    <= 1'b0;
      if (w_link_abort) begin
        r_state    <= ST_ERR;
        r_error    <= 1'b1;
        r_err_code <= ERR_LINK;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && link_up) begin
              r_state    <= ST_WAIT_RX;
              r_busy     <= 1'b1;
              r_timer    <= '0;
              r_count    <= '0;
              r_err_code <= ERR_NONE;
            end
          end
          ST_WAIT_RX: begin
            if (rx_calib_valid) begin
              r_operand <= rx_calib_delay;
              r_timer   <= '0;
              r_settle  <= '0;
              r_state   <= ST_SETTLE;
            end else if (&r_timer) begin
              r_state    <= ST_ERR;
              r_error    <= 1'b1;
              r_err_code <= ERR_TIMEOUT;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          ST_SETTLE: begin
            // Operand is frozen here; late strobes are simply not looked at
            if (r_settle == LP_SETTLE_LAST) r_state  <= ST_SAMPLE;
            else                            r_settle <= r_settle + SW'(1);
          end
          ST_SAMPLE: begin
            r_count <= r_count + NCW'(1);
            r_state <= (r_count == LP_LAST_SAMPLE) ? ST_CHECK : ST_WAIT_RX;
          end
          ST_CHECK: begin
            if (w_spread > LP_MAX_SPREAD) begin
              r_state    <= ST_ERR;
              r_error    <= 1'b1;
              r_err_code <= ERR_SPREAD;
            end else begin
              r_fine     <= w_sum[AW-1:kNumAvgLog2];
              r_fine_vld <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          ST_ERR: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign calc_calibdelay_rx = r_operand;
  assign fine_offset        = r_fine;
  assign fine_offset_valid  = r_fine_vld;
  assign busy               = r_busy;
  assign error              = r_error;
  assign err_code           = r_err_code;

endmodule
